led_pwm: RTL and testbench

LED_PWM -- requirements
Module: led_pwm

---
 rtl/led_pwm.sv | 213 +++++++++++++++++++++
 tb/tb_led_pwm.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pwm.sv
// led_pwm: memory-mapped three-channel (R/G/B) PWM LED controller with
// optional linear fading toward per-channel target levels.
//
// Parameters
//   BASE_ADDR   first of 8 consecutive register addresses (addr[15:3] decode)
//   FADE_DIV_W  fade step every 2^FADE_DIV_W PWM periods (must be >= 1)
//
// Ports
//   clk          single clock, all state updates on its rising edge
//   reset        asynchronous, active-high reset
//   addr         CPU address bus
//   data_in      CPU write data
//   data_out     registered read data (1-cycle latency, 0 when not selected)
//   write_enable CPU write strobe
//   r, g, b      PWM drive to the LED driver, high = lit
//
// Register map (offset = addr[2:0])
//   0/1/2  TGT_R/G/B  rw  target levels
//   3      CTRL       rw  bit0 EN, bit1 FADE, bit2 INV
//   4      STATUS     ro  bit0 BUSY, bit1..3 = cur != tgt for R/G/B
//   5/6/7  CUR_R/G/B  ro  current levels
module led_pwm #(
    parameter logic [15:0] BASE_ADDR  = 16'hD010,
    parameter int unsigned FADE_DIV_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    input  logic        write_enable,
    output logic        r,
    output logic        g,
    output logic        b
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [7:0]            pwm_ctr_q,  pwm_ctr_d;
    logic [FADE_DIV_W-1:0] fade_ctr_q, fade_ctr_d;
    logic [7:0]            tgt_r_q, tgt_r_d;
    logic [7:0]            tgt_g_q, tgt_g_d;
    logic [7:0]            tgt_b_q, tgt_b_d;
    logic [7:0]            cur_r_q, cur_r_d;
    logic [7:0]            cur_g_q, cur_g_d;
    logic [7:0]            cur_b_q, cur_b_d;
    logic [2:0]            ctrl_q,  ctrl_d;
    logic [7:0]            data_out_q, data_out_d;
    logic                  r_q, r_d;
    logic                  g_q, g_d;
    logic                  b_q, b_d;

    // ------------------------------------------------------------------
    // Decode and status
    // ------------------------------------------------------------------
    logic       sel;
    logic [2:0] off;
    logic       wr;
    logic       wrap;
    logic       step_now;
    logic       en, fade, inv;
    logic       ne_r, ne_g, ne_b, busy;
    logic [7:0] status;
    logic [7:0] rd_val;

    // One fade step toward the target, saturating at the target so it can
    // neither overshoot nor wrap past 0/255.
    function automatic logic [7:0] step_toward(input logic [7:0] cur,
                                               input logic [7:0] tgt);
        if (cur < tgt) begin
            return cur + 8'd1;
        end else if (cur > tgt) begin
            return cur - 8'd1;
        end
        return cur;
    endfunction

    // Current level only moves on a wrap: snap when not fading, step when
    // the fade divider is due. A cleared FADE therefore freezes the level
    // until the next wrap snaps it to target.
    function automatic logic [7:0] next_cur(input logic [7:0] cur,
                                            input logic [7:0] tgt,
                                            input logic       at_wrap,
                                            input logic       fading,
                                            input logic       do_step);
        if (!at_wrap) begin
            return cur;
        end else if (!fading) begin
            return tgt;
        end else if (do_step) begin
            return step_toward(cur, tgt);
        end
        return cur;
    endfunction

    always_comb begin
        sel      = (addr[15:3] == BASE_ADDR[15:3]);
        off      = addr[2:0];
        wr       = sel && write_enable;
        wrap     = (pwm_ctr_q == 8'hFF);
        step_now = &fade_ctr_q;
        en       = ctrl_q[0];
        fade     = ctrl_q[1];
        inv      = ctrl_q[2];

        ne_r   = (cur_r_q != tgt_r_q);
        ne_g   = (cur_g_q != tgt_g_q);
        ne_b   = (cur_b_q != tgt_b_q);
        busy   = ne_r | ne_g | ne_b;
        status = {4'b0000, ne_b, ne_g, ne_r, busy};
    end

    // ------------------------------------------------------------------
    // Register writes
    // ------------------------------------------------------------------
    always_comb begin
        tgt_r_d = tgt_r_q;
        tgt_g_d = tgt_g_q;
        tgt_b_d = tgt_b_q;
        ctrl_d  = ctrl_q;
        if (wr) begin
            case (off)
                3'd0:    tgt_r_d = data_in;
                3'd1:    tgt_g_d = data_in;
                3'd2:    tgt_b_d = data_in;
                3'd3:    ctrl_d  = data_in[2:0];
                default: ; // STATUS and CUR_* are read-only
            endcase
        end
    end

    // ------------------------------------------------------------------
    // PWM counter, fade divider and current levels
    // ------------------------------------------------------------------
    always_comb begin
        pwm_ctr_d  = pwm_ctr_q + 8'd1;

        fade_ctr_d = fade_ctr_q;
        if (wrap && fade) begin
            fade_ctr_d = fade_ctr_q + 1'b1;
        end

        // Uses the registered targets, so a target write landing on the
        // wrap edge is only seen at the following wrap.
        cur_r_d = next_cur(cur_r_q, tgt_r_q, wrap, fade, step_now);
        cur_g_d = next_cur(cur_g_q, tgt_g_q, wrap, fade, step_now);
        cur_b_d = next_cur(cur_b_q, tgt_b_q, wrap, fade, step_now);

        // Registered PWM outputs: one cycle behind pwm_ctr.
        r_d = (en & (pwm_ctr_q < cur_r_q)) ^ inv;
        g_d = (en & (pwm_ctr_q < cur_g_q)) ^ inv;
        b_d = (en & (pwm_ctr_q < cur_b_q)) ^ inv;
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    always_comb begin
        case (off)
            3'd0:    rd_val = tgt_r_q;
            3'd1:    rd_val = tgt_g_q;
            3'd2:    rd_val = tgt_b_q;
            3'd3:    rd_val = {5'b00000, ctrl_q};
            3'd4:    rd_val = status;
            3'd5:    rd_val = cur_r_q;
            3'd6:    rd_val = cur_g_q;
            default: rd_val = cur_b_q;
        endcase
        data_out_d = sel ? rd_val : '0;
    end

    // ------------------------------------------------------------------
    // Flops
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_ctr_q  <= '0;
            fade_ctr_q <= '0;
            tgt_r_q    <= '0;
            tgt_g_q    <= '0;
            tgt_b_q    <= '0;
            cur_r_q    <= '0;
            cur_g_q    <= '0;
            cur_b_q    <= '0;
            ctrl_q     <= '0;
            data_out_q <= '0;
            r_q        <= 1'b0;
            g_q        <= 1'b0;
            b_q        <= 1'b0;
        end else begin
            pwm_ctr_q  <= pwm_ctr_d;
            fade_ctr_q <= fade_ctr_d;
            tgt_r_q    <= tgt_r_d;
            tgt_g_q    <= tgt_g_d;
            tgt_b_q    <= tgt_b_d;
            cur_r_q    <= cur_r_d;
            cur_g_q    <= cur_g_d;
            cur_b_q    <= cur_b_d;
            ctrl_q     <= ctrl_d;
            data_out_q <= data_out_d;
            r_q        <= r_d;
            g_q        <= g_d;
            b_q        <= b_d;
        end
    end

    assign data_out = data_out_q;
    assign r        = r_q;
    assign g        = g_q;
    assign b        = b_q;

endmodule

// File: tb/tb_led_pwm.sv
// Directed testbench for led_pwm: bus access, steady PWM duty, duty
// extremes and inversion, fading up/down with retarget, FADE freeze/snap,
// and asynchronous reset mid-fade.
module tb_led_pwm;

    localparam logic [15:0] BASE = 16'hD010;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] addr;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        write_enable;
    logic        r, g, b;

    led_pwm #(
        .BASE_ADDR  (BASE),
        .FADE_DIV_W (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .addr         (addr),
        .data_in      (data_in),
        .data_out     (data_out),
        .write_enable (write_enable),
        .r            (r),
        .g            (g),
        .b            (b)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] phase;      // expected pwm_ctr: edges since reset, mod 256
    int         edges;      // edges since reset
    int         wrap_cnt;   // wraps since reset, counted by wait_wrap
    logic [7:0] wr_rdback;  // data_out right after a write edge
    logic [7:0] v;
    int         nr, ng, nb;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            phase <= '0;
            edges <= 0;
        end else begin
            phase <= phase + 8'd1;
            edges <= edges + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic wr_a(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        addr         = a;
        data_in      = d;
        write_enable = 1'b1;
        @(posedge clk);
        #1 wr_rdback = data_out;
        @(negedge clk);
        write_enable = 1'b0;
    endtask

    task automatic wr(input int unsigned off, input logic [7:0] d);
        wr_a(BASE + 16'(off), d);
    endtask

    task automatic rd_a(input logic [15:0] a, output logic [7:0] val);
        @(negedge clk);
        addr         = a;
        write_enable = 1'b0;
        @(posedge clk);
        #1 val = data_out;
    endtask

    task automatic chk_reg(input string tag, input int unsigned off, input logic [7:0] exp);
        logic [7:0] got;
        rd_a(BASE + 16'(off), got);
        chk(tag, 32'(got), 32'(exp));
    endtask

    // Advances to the negedge just after the next wrap edge.
    task automatic wait_wrap();
        bit found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (phase == 8'd0) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) chk("wrap_timeout", 0, 1);
        else wrap_cnt++;
    endtask

    task automatic wait_until(input int n);
        while (wrap_cnt < n) wait_wrap();
    endtask

    // Counts lit cycles of r/g/b over one full period (pwm_ctr 0..255).
    task automatic measure(output int cr, output int cg, output int cb);
        bit found = 1'b0;
        cr = 0; cg = 0; cb = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (phase == 8'd1) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) chk("period_timeout", 0, 1);
        for (int i = 0; i < 256; i++) begin
            cr += int'(r);
            cg += int'(g);
            cb += int'(b);
            @(negedge clk);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        addr         = '0;
        data_in      = '0;
        write_enable = 1'b0;
        wrap_cnt     = 0;
        repeat (2) @(negedge clk);
        chk("rst_rgb", 32'({r, g, b}), 0);
        chk("rst_dout", 32'(data_out), 0);
        reset = 1'b0;

        // First wrap lands on edge 256; TGT_R=255 makes r rise at edge 257.
        wr(3, 8'h01);
        wr(0, 8'hFF);
        for (int i = 0; i < 400; i++) begin
            if (r) break;
            @(negedge clk);
        end
        chk("first_r_edge", 32'(edges), 257);

        // Steady PWM
        wr(0, 8'd64);
        measure(nr, ng, nb);
        chk("duty_r64", nr, 64);
        chk("duty_g0", ng, 0);
        chk("duty_b0", nb, 0);

        // Duty extremes and inversion
        wr(1, 8'hFF);
        measure(nr, ng, nb);
        chk("duty_g255", ng, 255);
        wr(1, 8'h00);
        measure(nr, ng, nb);
        chk("duty_g0_again", ng, 0);
        wr(3, 8'h05);
        measure(nr, ng, nb);
        chk("inv_g0", ng, 256);
        chk("inv_r64", nr, 192);
        chk("inv_b0", nb, 256);
        wr(3, 8'h04);
        measure(nr, ng, nb);
        chk("dis_inv_r", nr, 256);
        wr(3, 8'h01);

        // Bus behaviour
        wait_wrap();
        chk_reg("cur_r_read", 5, 8'd64);
        wr(6, 8'hFF);
        chk_reg("cur_g_ro", 6, 8'd0);
        wr_a(BASE + 16'd8, 8'h55);
        rd_a(BASE + 16'd8, v);
        chk("unsel_read", 32'(v), 0);
        chk_reg("unsel_wr_noeff", 0, 8'd64);
        wr(3, 8'hF9);
        chk_reg("ctrl_mask", 3, 8'h01);
        wr(0, 8'h41);
        chk("rd_during_wr", 32'(wr_rdback), 32'd64);
        chk_reg("tgt_r_new", 0, 8'h41);
        chk_reg("status_r_ne", 4, 8'h03);

        // Fade up: B 0 -> 10, one step every 4 wraps
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset    = 1'b0;
        wrap_cnt = 0;
        wr(3, 8'h03);
        wr(2, 8'd10);
        wait_until(3);
        chk_reg("fade_w3", 7, 8'd0);
        wait_until(4);
        chk_reg("fade_w4", 7, 8'd1);
        wait_until(20);
        chk_reg("fade_w20", 7, 8'd5);
        wait_until(39);
        chk_reg("fade_w39", 7, 8'd9);
        chk_reg("busy_w39", 4, 8'h09);
        wait_until(40);
        chk_reg("fade_w40", 7, 8'd10);
        chk_reg("idle_w40", 4, 8'h00);

        // Freeze on FADE clear, snap at next wrap
        wr(1, 8'd20);
        wait_until(48);
        wr(3, 8'h01);
        chk_reg("frozen_g", 6, 8'd2);
        chk_reg("frozen_status", 4, 8'h05);
        wait_until(49);
        chk_reg("snap_g", 6, 8'd20);
        chk_reg("snap_status", 4, 8'h00);

        // Fade with retarget down at cur=7, plus R ramping toward 60
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset    = 1'b0;
        wrap_cnt = 0;
        wr(3, 8'h03);
        wr(2, 8'd10);
        wr(0, 8'd60);
        wait_until(28);
        chk_reg("retgt_w28", 7, 8'd7);
        wr(2, 8'd5);
        wait_until(32);
        chk_reg("down_w32", 7, 8'd6);
        wait_until(36);
        chk_reg("down_w36", 7, 8'd5);
        wait_until(44);
        chk_reg("hold_w44", 7, 8'd5);
        chk_reg("status_w44", 4, 8'h03);
        wait_until(120);
        chk_reg("cur_r_w120", 5, 8'd30);

        // Asynchronous reset mid-fade
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_rgb", 32'({r, g, b}), 0);
        chk("async_rst_dout", 32'(data_out), 0);
        @(negedge clk);
        reset = 1'b0;
        for (int unsigned o = 0; o < 8; o++) begin
            chk_reg($sformatf("post_rst_reg%0d", o), o, 8'h00);
        end
        chk("post_rst_rgb", 32'({r, g, b}), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
